execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage_if.sv | 21 ++
 rtl/execute_stage.sv | 185 ++++++++++++++++++
 tb/tb_execute_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Decode-to-execute bundle: operands and instruction in, registered result and busy back.
interface execute_stage_if;
  logic        in_valid;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] ins_dec_out;
  logic [31:0] alu_out;
  logic [4:0]  alu_rd;
  logic        alu_reg_w_en;
  logic        busy;

  modport master (
    output in_valid, alu_in1, alu_in2, ins_dec_out,
    input  alu_out, alu_rd, alu_reg_w_en, busy
  );

  modport slave (
    input  in_valid, alu_in1, alu_in2, ins_dec_out,
    output alu_out, alu_rd, alu_reg_w_en, busy
  );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: single-cycle ALU ops plus bit-serial shifts (one bit per cycle).
// Define RV32M_MUL_EN to add a 32-iteration shift-add MUL sharing the iteration datapath.
module execute_stage (
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave bus
);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  typedef enum logic {IDLE, ITER} state_t;
  typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA, K_MUL} kind_t;

  state_t      state, next_state;
  kind_t       kind_q, start_kind;
  logic [5:0]  count_q, start_count;
  logic [31:0] work_q, work_next, iter_result;
  logic [4:0]  rd_pend_q;
  logic [31:0] out_q;
  logic [4:0]  rd_q;
  logic        wen_q;
  logic        busy;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, shamt;
  logic [31:0] in1, op2, imm_i, comb_result;
  logic        is_op, is_imm, alt, f7_legal, accept, comb_done, start_iter, last_iter;
  logic        unused_rs_fields;

`ifdef RV32M_MUL_EN
  logic [31:0] acc_q, acc_next, mplier_q;
`endif

  assign opcode           = bus.ins_dec_out[6:0];
  assign rd               = bus.ins_dec_out[11:7];
  assign funct3           = bus.ins_dec_out[14:12];
  assign funct7           = bus.ins_dec_out[31:25];
  assign unused_rs_fields = ^bus.ins_dec_out[19:15];
  assign imm_i            = {{20{bus.ins_dec_out[31]}}, bus.ins_dec_out[31:20]};
  assign is_op            = (opcode == OPC_OP);
  assign is_imm           = (opcode == OPC_IMM);
  assign in1              = bus.alu_in1;
  assign op2              = is_imm ? imm_i : bus.alu_in2;
  assign shamt            = op2[4:0];
  assign alt              = funct7[5];
  assign accept           = bus.in_valid && (state == IDLE);
  assign last_iter        = (count_q == 6'd1);

  // funct7 only qualifies SUB/SRA in OP and the immediate shifts in OP-IMM
  always_comb begin
    f7_legal = 1'b0;
    if (is_op) begin
      f7_legal = (funct7 == 7'b0000000) ||
                 ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    end else if (is_imm) begin
      case (funct3)
        3'b001:  f7_legal = (funct7 == 7'b0000000);
        3'b101:  f7_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        default: f7_legal = 1'b1;
      endcase
    end
  end

  always_comb begin
    comb_done   = 1'b0;
    comb_result = '0;
    start_iter  = 1'b0;
    start_kind  = K_SLL;
    start_count = {1'b0, shamt};
    if ((is_op || is_imm) && f7_legal) begin
      comb_done = 1'b1;
      case (funct3)
        3'b000:  comb_result = (is_op && alt) ? (in1 - op2) : (in1 + op2);
        3'b001:  comb_result = in1;
        3'b010:  comb_result = {31'b0, ($signed(in1) < $signed(op2))};
        3'b011:  comb_result = {31'b0, (in1 < op2)};
        3'b100:  comb_result = in1 ^ op2;
        3'b101:  begin
                   comb_result = in1;
                   start_kind  = alt ? K_SRA : K_SRL;
                 end
        3'b110:  comb_result = in1 | op2;
        default: comb_result = in1 & op2;
      endcase
      // a zero shift amount finishes immediately with the operand unchanged
      if (((funct3 == 3'b001) || (funct3 == 3'b101)) && (shamt != 5'd0)) begin
        comb_done  = 1'b0;
        start_iter = 1'b1;
      end
    end else if (opcode == OPC_LUI) begin
      comb_done   = 1'b1;
      comb_result = {bus.ins_dec_out[31:12], 12'b0};
    end
`ifdef RV32M_MUL_EN
    else if (is_op && (funct7 == 7'b0000001) && (funct3 == 3'b000)) begin
      start_iter  = 1'b1;
      start_kind  = K_MUL;
      start_count = 6'd32;
    end
`endif
  end

  // for MUL the work register holds the left-shifting multiplicand
  always_comb begin
    case (kind_q)
      K_SRL:   work_next = work_q >> 1;
      K_SRA:   work_next = {work_q[31], work_q[31:1]};
      default: work_next = work_q << 1;
    endcase
    iter_result = work_next;
`ifdef RV32M_MUL_EN
    acc_next = mplier_q[0] ? (acc_q + work_q) : acc_q;
    if (kind_q == K_MUL) iter_result = acc_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && start_iter) next_state = ITER;
      ITER:    if (last_iter) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ITER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      work_q    <= '0;
      count_q   <= '0;
      kind_q    <= K_SLL;
      rd_pend_q <= '0;
`ifdef RV32M_MUL_EN
      acc_q     <= '0;
      mplier_q  <= '0;
`endif
    end else begin
      wen_q <= 1'b0;
      if (accept && comb_done) begin
        out_q <= comb_result;
        rd_q  <= rd;
        wen_q <= (rd != 5'd0);
      end else if (accept && start_iter) begin
        work_q    <= in1;
        kind_q    <= start_kind;
        count_q   <= start_count;
        rd_pend_q <= rd;
`ifdef RV32M_MUL_EN
        acc_q     <= '0;
        mplier_q  <= bus.alu_in2;
`endif
      end else if (state == ITER) begin
        work_q  <= work_next;
        count_q <= count_q - 6'd1;
`ifdef RV32M_MUL_EN
        acc_q    <= acc_next;
        mplier_q <= mplier_q >> 1;
`endif
        if (last_iter) begin
          out_q <= iter_result;
          rd_q  <= rd_pend_q;
          wen_q <= (rd_pend_q != 5'd0);
        end
      end
    end
  end

  assign bus.alu_out      = out_q;
  assign bus.alu_rd       = rd_q;
  assign bus.alu_reg_w_en = wen_q;
  assign bus.busy         = busy;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table for single-cycle ops, hand sequences
// for iterative shifts, reset abort and the optional RV32M_MUL_EN multiply.
module tb_execute_stage;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  execute_stage_if bus();

  execute_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic [4:0]  rd;
    logic        wen;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] ins, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] o, input logic [4:0] rd,
                              input logic wen);
    vec_t v;
    v.name = n; v.ins = ins; v.a = a; v.b = b; v.out = o; v.rd = rd; v.wen = wen;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid    = 1'b1;
    bus.ins_dec_out = ins;
    bus.alu_in1     = a;
    bus.alu_in2     = b;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // accept, then watch busy/w_en edge by edge until the k-th iteration writes back
  task automatic runIter(input string name, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input int k, input logic [31:0] exp_out,
                         input logic [4:0] exp_rd, input bit pulse);
    logic [31:0] dummy;
    dummy = r_type(7'b0000000, 3'b000, 5'd9);
    applyStimulus(ins, a, b);
    tick();
    bus.in_valid = 1'b0;
    checkOutput({name, "_busy_start"}, bus.busy, 1);
    checkOutput({name, "_wen_start"}, bus.alu_reg_w_en, 0);
    for (int j = 1; j <= k; j++) begin
      if (pulse) applyStimulus(dummy, 32'h1, 32'h1);
      tick();
      bus.in_valid = 1'b0;
      if (j < k) begin
        checkOutput({name, "_busy_mid"}, bus.busy, 1);
        checkOutput({name, "_wen_mid"}, bus.alu_reg_w_en, 0);
      end else begin
        checkOutput({name, "_busy_done"}, bus.busy, 0);
        checkOutput({name, "_wen_done"}, bus.alu_reg_w_en, 1);
        checkOutput({name, "_out"}, bus.alu_out, exp_out);
        checkOutput({name, "_rd"}, bus.alu_rd, exp_rd);
      end
    end
    tick();
    checkOutput({name, "_wen_after"}, bus.alu_reg_w_en, 0);
    checkOutput({name, "_rd_after"}, bus.alu_rd, exp_rd);
    checkOutput({name, "_out_after"}, bus.alu_out, exp_out);
    checkOutput({name, "_busy_after"}, bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.ins_dec_out = '0;
    bus.alu_in1     = '0;
    bus.alu_in2     = '0;

    vecs.push_back(mk("add",      r_type(7'h00, 3'b000, 5'd3),  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'd3,  1'b1));
    vecs.push_back(mk("sub",      r_type(7'h20, 3'b000, 5'd4),  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 5'd4,  1'b1));
    vecs.push_back(mk("slt",      r_type(7'h00, 3'b010, 5'd6),  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'd6,  1'b1));
    vecs.push_back(mk("sltu",     r_type(7'h00, 3'b011, 5'd6),  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd6,  1'b1));
    vecs.push_back(mk("xor",      r_type(7'h00, 3'b100, 5'd8),  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 5'd8,  1'b1));
    vecs.push_back(mk("or",       r_type(7'h00, 3'b110, 5'd9),  32'h12340000, 32'h00005678, 32'h12345678, 5'd9,  1'b1));
    vecs.push_back(mk("and",      r_type(7'h00, 3'b111, 5'd10), 32'hFFFF0000, 32'h12345678, 32'h12340000, 5'd10, 1'b1));
    vecs.push_back(mk("sra_zero", r_type(7'h20, 3'b101, 5'd11), 32'h80000000, 32'h00000020, 32'h80000000, 5'd11, 1'b1));
    vecs.push_back(mk("addi_neg", i_type(12'hFFF, 3'b000, 5'd12), 32'h00000010, 32'h00000055, 32'h0000000F, 5'd12, 1'b1));
    vecs.push_back(mk("addi_b30", i_type(12'h400, 3'b000, 5'd13), 32'h00000001, 32'h00000000, 32'h00000401, 5'd13, 1'b1));
    vecs.push_back(mk("xori",     i_type(12'hFFF, 3'b100, 5'd14), 32'h0000FFFF, 32'h00000000, 32'hFFFF0000, 5'd14, 1'b1));
    vecs.push_back(mk("slti",     i_type(12'hFFF, 3'b010, 5'd15), 32'h80000000, 32'h00000000, 32'h00000001, 5'd15, 1'b1));
    vecs.push_back(mk("sltiu",    i_type(12'hFFF, 3'b011, 5'd16), 32'h00000005, 32'h00000000, 32'h00000001, 5'd16, 1'b1));
    vecs.push_back(mk("lui",      lui(20'hABCDE, 5'd7),           32'h00000123, 32'h00000456, 32'hABCDE000, 5'd7,  1'b1));
    vecs.push_back(mk("slli_zero", i_type(12'h000, 3'b001, 5'd18), 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 5'd18, 1'b1));
    vecs.push_back(mk("load_opc", {12'h000, 5'd1, 3'b010, 5'd20, 7'b0000011}, 32'h1, 32'h2, 32'hDEADBEEF, 5'd18, 1'b0));
    vecs.push_back(mk("bad_f7_xor", r_type(7'h20, 3'b100, 5'd21), 32'h1, 32'h2, 32'hDEADBEEF, 5'd18, 1'b0));
    vecs.push_back(mk("bad_slli", i_type(12'h403, 3'b001, 5'd22), 32'h1, 32'h2, 32'hDEADBEEF, 5'd18, 1'b0));

    tick();
    tick();
    checkOutput("reset_out", bus.alu_out, 32'h0);
    checkOutput("reset_rd", bus.alu_rd, 32'h0);
    checkOutput("reset_wen", bus.alu_reg_w_en, 0);
    checkOutput("reset_busy", bus.busy, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ins, vecs[i].a, vecs[i].b);
      tick();
      bus.in_valid = 1'b0;
      checkOutput({vecs[i].name, "_out"}, bus.alu_out, vecs[i].out);
      checkOutput({vecs[i].name, "_rd"}, bus.alu_rd, vecs[i].rd);
      checkOutput({vecs[i].name, "_wen"}, bus.alu_reg_w_en, vecs[i].wen);
      checkOutput({vecs[i].name, "_busy"}, bus.busy, 0);
    end

    // the write strobe lasts exactly one cycle and the result holds afterwards
    applyStimulus(r_type(7'h00, 3'b000, 5'd3), 32'h7FFFFFFF, 32'h00000001);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("add1_wen", bus.alu_reg_w_en, 1);
    checkOutput("add1_busy", bus.busy, 0);
    tick();
    checkOutput("add1_wen_idle", bus.alu_reg_w_en, 0);
    checkOutput("add1_out_hold", bus.alu_out, 32'h80000000);
    checkOutput("add1_rd_hold", bus.alu_rd, 3);
    checkOutput("add1_busy_idle", bus.busy, 0);

    runIter("srai4", i_type({7'b0100000, 5'd4}, 3'b101, 5'd5), 32'h80000010, 32'h0, 4, 32'hF8000001, 5'd5, 1'b1);
    runIter("srl1", r_type(7'h00, 3'b101, 5'd16), 32'h80000000, 32'h00000001, 1, 32'h40000000, 5'd16, 1'b0);
    runIter("slli31", i_type(12'h01F, 3'b001, 5'd19), 32'h00000001, 32'h0, 31, 32'h80000000, 5'd19, 1'b0);

    applyStimulus(i_type(12'h005, 3'b000, 5'd0), 32'h00000001, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("addi_x0_wen", bus.alu_reg_w_en, 0);
    checkOutput("addi_x0_busy", bus.busy, 0);
    tick();
    checkOutput("addi_x0_wen_late", bus.alu_reg_w_en, 0);

    // reset lands in the second busy cycle of a 10-bit shift
    applyStimulus(r_type(7'h00, 3'b001, 5'd15), 32'h00000001, 32'd10);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("sll10_busy1", bus.busy, 1);
    tick();
    checkOutput("sll10_busy2", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_out", bus.alu_out, 32'h0);
    checkOutput("abort_rd", bus.alu_rd, 32'h0);
    checkOutput("abort_wen", bus.alu_reg_w_en, 0);
    checkOutput("abort_busy", bus.busy, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput("abort_no_late_wen", bus.alu_reg_w_en, 0);
    end
    checkOutput("abort_out_later", bus.alu_out, 32'h0);

`ifdef RV32M_MUL_EN
    runIter("mul", r_type(7'b0000001, 3'b000, 5'd17), 32'hFFFFFFFF, 32'h00000003, 32, 32'hFFFFFFFD, 5'd17, 1'b0);
`else
    applyStimulus(r_type(7'b0000001, 3'b000, 5'd17), 32'hFFFFFFFF, 32'h00000003);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("mul_off_wen", bus.alu_reg_w_en, 0);
    checkOutput("mul_off_busy", bus.busy, 0);
    checkOutput("mul_off_out", bus.alu_out, 32'h0);
    tick();
    checkOutput("mul_off_busy_next", bus.busy, 0);
    checkOutput("mul_off_wen_next", bus.alu_reg_w_en, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
